// File: rtl/fifo_queue_reader_if.sv
// Bundles the queue-pop side (q_get/q_empty/q_data) and the downstream valid/ready stream.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer stalls the reader; q_empty stalls new pops.
interface fifo_queue_reader_if #(
  parameter int WIDTH = 16
);
  logic             q_get;
  logic             q_empty;
  logic [WIDTH-1:0] q_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Reader side: pops the queue and sources the output stream.
  modport master (
    output q_get,
    output out_valid,
    output out_data,
    input  q_empty,
    input  q_data,
    input  out_ready
  );

  // Environment side: the queue and the downstream consumer.
  modport slave (
    input  q_get,
    input  out_valid,
    input  out_data,
    output q_empty,
    output q_data,
    output out_ready
  );
endinterface

// File: rtl/fifo_queue_reader.sv
// Pops one word at a time from the 8-deep queue into a single-entry valid/ready output slot.
// Latency: IDLE decision at N, q_get at N+1, word latched end of N+2, out_valid at N+3.
// Backpressure: a pop only starts when the slot is free; bursts of MAX_BURST are followed by GAP_CYCLES idle cycles.
module fifo_queue_reader #(
  parameter int WIDTH      = 16,
  parameter int MAX_BURST  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int COUNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_drain_en,
  input  logic               i_flush,
  fifo_queue_reader_if.master bus,
  output logic [COUNT_W-1:0] o_words_out,
  output logic               o_busy
);

  // Burst counter holds 0..MAX_BURST-1; gap counter holds 0..GAP_CYCLES-1.
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_CAPTURE = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_q_get;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [COUNT_W-1:0] r_words_out;
  logic [BW-1:0]      r_burst_cnt;
  logic [GW-1:0]      r_gap_cnt;
  logic               r_discard;

  state_t             w_state_nxt;
  logic               w_q_get_nxt;
  logic [BW-1:0]      w_burst_nxt;
  logic [GW-1:0]      w_gap_nxt;
  logic               w_discard_nxt;
  logic               w_load;
  logic               w_slot_free;
  logic               w_hs;

  // A flushed word is never counted, even if the consumer is ready in that cycle.
  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_hs        = r_out_valid && bus.out_ready && !i_flush;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, pop strobe, burst/gap counters and capture decision.
  always_comb begin
    w_state_nxt   = r_state;
    w_q_get_nxt   = 1'b0;
    w_burst_nxt   = r_burst_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_discard_nxt = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_drain_en || i_flush) begin
          w_burst_nxt = '0;
        end
        if (i_drain_en && !bus.q_empty && w_slot_free && !i_flush) begin
          w_state_nxt = S_FETCH;
          w_q_get_nxt = 1'b1;
        end
      end
      S_FETCH: begin
        // The pop is already issued; a flush here only marks the word for discard.
        w_state_nxt   = S_CAPTURE;
        w_discard_nxt = i_flush;
      end
      S_CAPTURE: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
          w_burst_nxt = '0;
        end else begin
          w_load = !r_discard;
          if (r_burst_cnt == BURST_LAST) begin
            w_burst_nxt = '0;
            w_gap_nxt   = '0;
            w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else begin
            w_burst_nxt = r_burst_cnt + BW'(1);
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
          w_burst_nxt = '0;
          w_gap_nxt   = '0;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap_cnt + GW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pop strobe, counters and discard marker.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q_get     <= 1'b0;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
      r_discard   <= 1'b0;
    end else begin
      r_q_get     <= w_q_get_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_discard   <= w_discard_nxt;
    end
  end

  // Output slot: load on capture, drop on flush, release on handshake.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (i_flush) begin
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_valid <= 1'b1;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_load) begin
        r_out_data <= bus.q_data;
      end
    end
  end

  // Delivered-word counter, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_words_out <= '0;
    end else if (w_hs) begin
      r_words_out <= r_words_out + COUNT_W'(1);
    end
  end

  assign bus.q_get     = r_q_get;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_words_out   = r_words_out;
  assign o_busy        = (r_state != S_IDLE);

endmodule
